// File: rtl/rob_tag_release_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rob_pkg
// Description : Shared sizing constants, the retire-tracker entry record and
//               a small mask helper for the tag-release slice.
// Revision    : 1.0  initial release
// ============================================================================
package rob_pkg;

  localparam int TAG_WIDTH = 5;
  localparam int DEPTH     = 16;
  localparam int IDX_W     = $clog2(DEPTH);

  // One tracker slot. old_tag is the physical tag the destination overwrote;
  // it goes back to the free list when the slot retires with has_dst set.
  typedef struct packed {
    logic                 valid;
    logic                 done;
    logic                 has_dst;
    logic [TAG_WIDTH-1:0] old_tag;
  } rob_entry_t;

  // Low-order mask with m ones (m = 0..4).
  function automatic logic [3:0] low_mask4(input logic [2:0] m);
    low_mask4 = 4'((5'd1 << m) - 5'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rob_tag_release_if.sv
`default_nettype none
// ============================================================================
// Module      : rob_tag_release_if
// Description : Bundle of dispatch, completion, flush and free-list signals
//               around the tag-release tracker.
//               master : rename / execute / free-list side
//               slave  : the tracker itself
// Revision    : 1.0  initial release
// ============================================================================
interface rob_tag_release_if;
  import rob_pkg::*;

  logic [3:0]             disp_en;
  logic [3:0]             disp_has_dst;
  logic [4*TAG_WIDTH-1:0] disp_old_tag;
  logic                   disp_ready;
  logic [4*IDX_W-1:0]     disp_idx;
  logic [1:0]             cmpl_en;
  logic [2*IDX_W-1:0]     cmpl_idx;
  logic                   flush;
  logic                   free_full;
  logic [7:0]             free_en;
  logic [4*TAG_WIDTH-1:0] free_tag;
  logic [2:0]             retire_cnt;
  logic [IDX_W:0]         count;
  logic                   empty;

  modport master (
    output disp_en, disp_has_dst, disp_old_tag, cmpl_en, cmpl_idx, flush,
           free_full,
    input  disp_ready, disp_idx, free_en, free_tag, retire_cnt, count, empty
  );

  modport slave (
    input  disp_en, disp_has_dst, disp_old_tag, cmpl_en, cmpl_idx, flush,
           free_full,
    output disp_ready, disp_idx, free_en, free_tag, retire_cnt, count, empty
  );

endinterface
`default_nettype wire

// File: rtl/rob_tag_release_compact.sv
`default_nettype none
// ============================================================================
// Module      : tag_compact4
// Description : Combinational 4-lane compactor. Lanes with keep set are packed
//               into output slots 0..m-1 in lane order; unused output slots
//               are zero.
//   i_tags  : 4 packed tags, lane i at [i*TAG_W +: TAG_W]
//   i_keep  : per-lane keep bit
//   o_tags  : packed result
//   o_count : number of kept lanes (0..4)
// Revision    : 1.0  initial release
// ============================================================================
module tag_compact4 #(
  parameter int TAG_W = rob_pkg::TAG_WIDTH
) (
  input  logic [4*TAG_W-1:0] i_tags,
  input  logic [3:0]         i_keep,
  output logic [4*TAG_W-1:0] o_tags,
  output logic [2:0]         o_count
);

  // w_prefix[i] = number of kept lanes below lane i = its output slot.
  logic [2:0] w_prefix [4];

  always_comb begin
    w_prefix[0] = 3'd0;
    for (int i = 1; i < 4; i++) begin
      w_prefix[i] = w_prefix[i-1] + 3'(i_keep[i-1]);
    end
    o_tags = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (i_keep[i] && (w_prefix[i] == 3'(j))) begin
          o_tags[j*TAG_W +: TAG_W] = i_tags[i*TAG_W +: TAG_W];
        end
      end
    end
  end

  assign o_count = w_prefix[3] + 3'(i_keep[3]);

endmodule
`default_nettype wire

// File: rtl/rob_tag_release.sv
`default_nettype none
// ============================================================================
// Module      : rob_tag_release
// Description : In-order retire tracker. Accepts up to 4 dispatches per cycle,
//               marks entries done from 2 completion ports, retires up to 4
//               consecutive done entries from the head and hands their old
//               physical tags to the free list through registered outputs.
//   clk     : clock
//   rst     : synchronous active-high reset (same effect as flush)
//   rob_bus : dispatch / completion / flush / free-list bundle (slave side)
// Revision    : 1.0  initial release
// ============================================================================
module rob_tag_release
  import rob_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  rob_tag_release_if.slave rob_bus
);

  localparam int c_PTR_W = IDX_W + 1;

  rob_entry_t             r_entries [DEPTH];
  logic [c_PTR_W-1:0]     r_head;
  logic [c_PTR_W-1:0]     r_tail;
  logic [3:0]             r_free_en;
  logic [4*TAG_WIDTH-1:0] r_free_tag;
  logic [2:0]             r_retire_cnt;

  logic [c_PTR_W-1:0]     w_count;
  logic                   w_disp_ready;
  logic                   w_disp_fire;
  logic [2:0]             w_disp_n;
  logic [IDX_W-1:0]       w_disp_slot_idx [4];
  logic [IDX_W-1:0]       w_scan_idx [4];
  logic [3:0]             w_elig;
  logic [3:0]             w_keep;
  logic [2:0]             w_ret_k;
  logic [4*TAG_WIDTH-1:0] w_scan_tags;
  logic [4*TAG_WIDTH-1:0] w_packed_tags;
  logic [2:0]             w_keep_m;

  // ---------------------------------------------------------------- occupancy
  // The wrap bit in both pointers makes tail-head equal DEPTH when full.
  assign w_count      = r_tail - r_head;
  assign w_disp_ready = (w_count <= c_PTR_W'(DEPTH - 4));
  assign w_disp_fire  = w_disp_ready && !rob_bus.flush;
  assign w_disp_n     = 3'(rob_bus.disp_en[0]) + 3'(rob_bus.disp_en[1])
                      + 3'(rob_bus.disp_en[2]) + 3'(rob_bus.disp_en[3]);

  // ------------------------------------------------------ per-slot index math
  for (genvar i = 0; i < 4; i++) begin : g_slot
    assign w_disp_slot_idx[i] = r_tail[IDX_W-1:0] + IDX_W'(i);
    assign rob_bus.disp_idx[i*IDX_W +: IDX_W] = w_disp_slot_idx[i];

    assign w_scan_idx[i] = r_head[IDX_W-1:0] + IDX_W'(i);
    assign w_scan_tags[i*TAG_WIDTH +: TAG_WIDTH] = r_entries[w_scan_idx[i]].old_tag;
    assign w_keep[i] = w_elig[i] && r_entries[w_scan_idx[i]].has_dst;

    // Eligibility is a thermometer: slot i retires only if all older slots do.
    // A full free list blocks the whole chain at slot 0.
    if (i == 0) begin : g_first
      assign w_elig[i] = !rob_bus.free_full
                       && r_entries[w_scan_idx[i]].valid
                       && r_entries[w_scan_idx[i]].done;
    end else begin : g_chain
      assign w_elig[i] = w_elig[i-1]
                       && r_entries[w_scan_idx[i]].valid
                       && r_entries[w_scan_idx[i]].done;
    end
  end

  assign w_ret_k = 3'(w_elig[0]) + 3'(w_elig[1]) + 3'(w_elig[2]) + 3'(w_elig[3]);

  tag_compact4 #(
    .TAG_W   (TAG_WIDTH)
  ) u_compact (
    .i_tags  (w_scan_tags),
    .i_keep  (w_keep),
    .o_tags  (w_packed_tags),
    .o_count (w_keep_m)
  );

  // ------------------------------------------------------------ entry array
  // Update order inside the non-flush branch: completion, retire, dispatch.
  // Completion is gated by the registered valid, so it cannot touch a slot
  // being written by dispatch this cycle, and dispatch only targets free
  // slots, so it never collides with a retiring one.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_entries[i] <= '0;
      end
    end else if (rob_bus.flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_entries[i].valid <= 1'b0;
      end
    end else begin
      for (int j = 0; j < 2; j++) begin
        if (rob_bus.cmpl_en[j]
            && r_entries[rob_bus.cmpl_idx[j*IDX_W +: IDX_W]].valid) begin
          r_entries[rob_bus.cmpl_idx[j*IDX_W +: IDX_W]].done <= 1'b1;
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (w_elig[i]) begin
          r_entries[w_scan_idx[i]].valid <= 1'b0;
        end
      end
      if (w_disp_fire) begin
        for (int i = 0; i < 4; i++) begin
          if (rob_bus.disp_en[i]) begin
            r_entries[w_disp_slot_idx[i]] <= '{
              valid:   1'b1,
              done:    1'b0,
              has_dst: rob_bus.disp_has_dst[i],
              old_tag: rob_bus.disp_old_tag[i*TAG_WIDTH +: TAG_WIDTH]
            };
          end
        end
      end
    end
  end

  // --------------------------------------------------------------- pointers
  always_ff @(posedge clk) begin
    if (rst || rob_bus.flush) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      r_head <= r_head + c_PTR_W'(w_ret_k);
      if (w_disp_fire) begin
        r_tail <= r_tail + c_PTR_W'(w_disp_n);
      end
    end
  end

  // ------------------------------------------------------ free-list outputs
  // Registered so the free list's full -> write-enable path stays open.
  always_ff @(posedge clk) begin
    if (rst || rob_bus.flush) begin
      r_free_en    <= '0;
      r_free_tag   <= '0;
      r_retire_cnt <= '0;
    end else begin
      r_free_en    <= low_mask4(w_keep_m);
      r_free_tag   <= w_packed_tags;
      r_retire_cnt <= w_ret_k;
    end
  end

  assign rob_bus.free_en    = {4'b0000, r_free_en};
  assign rob_bus.free_tag   = r_free_tag;
  assign rob_bus.retire_cnt = r_retire_cnt;
  assign rob_bus.count      = w_count;
  assign rob_bus.empty      = (w_count == '0);
  assign rob_bus.disp_ready = w_disp_ready;

endmodule
`default_nettype wire
